// File: rtl/modulo_ctrl.sv
// -----------------------------------------------------------------------------
// modulo_ctrl -- prescaled modulo-16 up/down counter with IDLE/RUN/PAUSE control
//
// A prescaler divides CLK by DIV. Each time it completes a period while the FSM
// is in RUN, COUNT steps once (up or down, modulo 16). Control inputs are level
// sampled every cycle and resolved in fixed priority CLEAR > LOAD > STOP > START.
//
// Parameters
//   DIV        clock cycles per count step (2 .. 2^31-1)
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   START      begin counting from IDLE, or resume from PAUSE
//   STOP       pause counting (only meaningful in RUN)
//   CLEAR      return to IDLE with COUNT = 0
//   LOAD       load LOAD_VAL into COUNT, state unchanged
//   LOAD_VAL   value loaded by LOAD
//   ADD_SUB    1 = count up, 0 = count down
//   COUNT      registered count value
//   STATE      00 = IDLE, 01 = RUN, 10 = PAUSE
//   TICK       one-cycle pulse in the first cycle COUNT shows a stepped value
//   WRAP       one-cycle pulse with TICK when the step wrapped 15->0 or 0->15
//   DIR        direction used for the most recent or next step (1 = up)
//
// Build option
//   MODULO_CTRL_AUTO_REVERSE_EN  when defined, DIR is captured on entry to RUN
//   and a step that would wrap instead bounces one place back and inverts DIR;
//   WRAP is then never raised.
// -----------------------------------------------------------------------------
module modulo_ctrl #(
  parameter int unsigned DIV = 12587500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       LOAD,
  input  logic [3:0] LOAD_VAL,
  input  logic       ADD_SUB,
  output logic [3:0] COUNT,
  output logic [1:0] STATE,
  output logic       TICK,
  output logic       WRAP,
  output logic       DIR
);

  localparam int unsigned    PW        = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;
  logic          wrap_q,  wrap_d;
  logic          dir_q,   dir_d;

  // Next-state and datapath decode.
  // NOTE: every variable gets its hold/default value first so no path through
  // the if-chain leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
    dir_d   = dir_q;
`else
    dir_d   = ADD_SUB;
`endif

    if (CLEAR) begin
      state_d = S_IDLE;
      count_d = 4'd0;
      presc_d = '0;
    end else if (LOAD) begin
      // A load restarts the prescaler period and swallows any step due now.
      count_d = LOAD_VAL;
      presc_d = '0;
    end else if (STOP) begin
      // Pausing freezes the prescaler; a step due this cycle is dropped.
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (START && (state_q != S_RUN)) begin
      state_d = S_RUN;
      // From IDLE start a fresh period; from PAUSE keep the frozen phase.
      if (state_q == S_IDLE) presc_d = '0;
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
      dir_d = ADD_SUB;
`endif
    end else if (state_q == S_RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
        // At either end, bounce back one place instead of wrapping.
        if (dir_q && (count_q == 4'd15)) begin
          count_d = 4'd14;
          dir_d   = 1'b0;
        end else if (!dir_q && (count_q == 4'd0)) begin
          count_d = 4'd1;
          dir_d   = 1'b1;
        end else begin
          count_d = dir_q ? count_q + 4'd1 : count_q - 4'd1;
        end
`else
        // 4-bit arithmetic wraps naturally; flag the wrap edge explicitly.
        count_d = ADD_SUB ? count_q + 4'd1 : count_q - 4'd1;
        wrap_d  = ADD_SUB ? (count_q == 4'd15) : (count_q == 4'd0);
`endif
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
    end
  end

  assign COUNT = count_q;
  assign STATE = state_q;
  assign TICK  = tick_q;
  assign WRAP  = wrap_q;
  assign DIR   = dir_q;

endmodule

// File: tb/tb_modulo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modulo_ctrl -- bench for modulo_ctrl with DIV = 4
//
// Directed scenarios exercise start-up stepping, wrap, pause/resume phase,
// STOP against a due step, CLEAR/LOAD/START collision and mid-run reset; a
// randomized phase follows. Every cycle is also compared against a
// behavioural model that tracks the counter with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_modulo_ctrl;

  localparam int DIV   = 4;
  localparam int IDLE  = 0;
  localparam int RUN   = 1;
  localparam int PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, load, add_sub;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [1:0] state;
  logic       tick, wrap, dir;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_state, m_count, m_presc;
  bit m_tick, m_wrap, m_dir;

  modulo_ctrl #(.DIV(DIV)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .STOP     (stop),
    .CLEAR    (clear),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .ADD_SUB  (add_sub),
    .COUNT    (count),
    .STATE    (state),
    .TICK     (tick),
    .WRAP     (wrap),
    .DIR      (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One step of the counter, taken directly from the behavioural rules.
  task automatic do_step();
    bit up;
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
    up = m_dir;
    if (up && m_count == 15) begin
      m_count = 14; m_dir = 0;
    end else if (!up && m_count == 0) begin
      m_count = 1;  m_dir = 1;
    end else begin
      m_count = up ? m_count + 1 : m_count - 1;
    end
`else
    up = add_sub;
    m_wrap  = up ? (m_count == 15) : (m_count == 0);
    m_count = up ? (m_count + 1) % 16 : (m_count + 15) % 16;
`endif
    m_tick = 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_state = IDLE; m_count = 0; m_presc = 0;
      m_tick = 0; m_wrap = 0; m_dir = 1;
      return;
    end
    m_tick = 0;
    m_wrap = 0;
`ifndef MODULO_CTRL_AUTO_REVERSE_EN
    m_dir = add_sub;
`endif
    if (clear) begin
      m_state = IDLE; m_count = 0; m_presc = 0;
    end else if (load) begin
      m_count = int'(load_val); m_presc = 0;
    end else if (stop) begin
      if (m_state == RUN) m_state = PAUSE;
    end else if (start && m_state != RUN) begin
      if (m_state == IDLE) m_presc = 0;
      m_state = RUN;
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
      m_dir = add_sub;
`endif
    end else if (m_state == RUN) begin
      m_presc = (m_presc + 1) % DIV;
      if (m_presc == 0) do_step();
    end
  endtask

  // Apply controls for one clock, advance the model, compare on the falling edge.
  task automatic step(input bit r, input bit st, input bit sp, input bit cl, input bit ld);
    rst = r; start = st; stop = sp; clear = cl; load = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("m_count", count, m_count);
    check("m_state", state, m_state);
    check("m_tick",  tick,  m_tick);
    check("m_wrap",  wrap,  m_wrap);
    check("m_dir",   dir,   m_dir);
  endtask

  int c_frozen;

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; load = 0;
    load_val = 4'd0; add_sub = 1;
    m_state = IDLE; m_count = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_dir = 1;

    // Reset state
    step(1, 0, 0, 0, 0);
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_dir",   dir,   1);
    check("rst_tick",  tick,  0);

    // Start, count up at DIV-cycle intervals
    step(0, 1, 0, 0, 0);
    check("run_state", state, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 0);
      check("run_count", count, i / 4);
      check("run_tick",  tick,  (i % 4) == 0);
    end

    // Wrap at 15 going up
    step(0, 0, 0, 1, 0);
    load_val = 4'd15;
    step(0, 0, 0, 0, 1);
    check("load_count", count, 15);
    check("load_state", state, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    check("wrap_tick", tick, 1);
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
    check("wrap_count", count, 14);
    check("wrap_dir",   dir,   0);
    check("wrap_flag",  wrap,  0);
`else
    check("wrap_count", count, 0);
    check("wrap_flag",  wrap,  1);
`endif
    step(0, 0, 0, 0, 0);
    check("wrap_pulse", wrap, 0);

    // Pause two cycles after a step, hold, resume: step lands 2 cycles later
    step(0, 0, 0, 0, 0);
    c_frozen = int'(count);
    step(0, 0, 1, 0, 0);
    check("pause_state", state, 2);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      check("pause_hold", count, c_frozen);
      check("pause_tick", tick, 0);
    end
    step(0, 1, 0, 0, 0);
    check("resume_state", state, 1);
    step(0, 0, 0, 0, 0);
    check("resume_early", tick, 0);
    step(0, 0, 0, 0, 0);
    check("resume_tick", tick, 1);
`ifdef MODULO_CTRL_AUTO_REVERSE_EN
    check("resume_count", count, (c_frozen + 15) % 16);
`else
    check("resume_count", count, (c_frozen + 1) % 16);
`endif

    // STOP exactly when a step is due: step dropped
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    c_frozen = int'(count);
    step(0, 0, 1, 0, 0);
    check("stopdue_state", state, 2);
    check("stopdue_count", count, c_frozen);
    check("stopdue_tick",  tick,  0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("stopdue_resume", tick, 1);

    // CLEAR + LOAD + START together in RUN
    load_val = 4'd9;
    step(0, 1, 0, 1, 1);
    check("clr_state", state, 0);
    check("clr_count", count, 0);
    check("clr_tick",  tick,  0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      check("clr_idle_tick", tick, 0);
    end

    // Reset mid-run with COUNT = 7
    step(0, 1, 0, 0, 0);
    load_val = 4'd7;
    step(0, 0, 0, 0, 1);
    check("mid_load", count, 7);
    add_sub = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("midrst_state", state, 0);
    check("midrst_count", count, 0);
    check("midrst_dir",   dir,   1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      check("midrst_tick",  tick,  0);
      check("midrst_idle",  state, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, st, sp, cl, ld;
      r  = ($urandom_range(0, 299) == 0);
      cl = ($urandom_range(0, 39)  == 0);
      ld = ($urandom_range(0, 29)  == 0);
      sp = ($urandom_range(0, 11)  == 0);
      st = ($urandom_range(0, 5)   == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) add_sub = ~add_sub;
      step(r, st, sp, cl, ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
